// File: rtl/lv_owt_tx_arb_pkg.sv
// Shared types and constants for the LV-side OWT transmit arbiter.
package lv_owt_tx_arb_pkg;

   localparam int OWT_ARB_ST_W = 2;

   typedef enum logic [OWT_ARB_ST_W-1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } owt_arb_st_e;

   typedef logic [1:0] owt_gnt_t;

   localparam owt_gnt_t OWT_GNT_NONE = 2'd0;
   localparam owt_gnt_t OWT_GNT_WDG  = 2'd1;
   localparam owt_gnt_t OWT_GNT_SPI  = 2'd2;
   localparam owt_gnt_t OWT_GNT_SCAN = 2'd3;

   // Round-robin pointer between the two fair requesters
   localparam logic OWT_RR_SPI  = 1'b0;
   localparam logic OWT_RR_SCAN = 1'b1;

   // Pointer after a completed transaction: flips only for spi/scan, wdg leaves it alone
   function automatic logic owt_rr_next(input logic rr, input owt_gnt_t gnt);
      logic nxt;
      case (gnt)
         OWT_GNT_SPI:  nxt = OWT_RR_SCAN;
         OWT_GNT_SCAN: nxt = OWT_RR_SPI;
         default:      nxt = rr;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/lv_owt_tx_arb_pick.sv
// Combinational winner selection: wdg has absolute priority, spi/scan share a round-robin pointer.
module lv_owt_arb_pick
   import lv_owt_tx_arb_pkg::*;
(
   input  logic       i_wdg_req,
   input  logic       i_spi_req,
   input  logic       i_scan_req,
   input  logic       i_rr,
   output logic [1:0] o_win_id
);

   // Pick the winner: wdg first, then the rr holder, then the other fair requester
   always_comb begin
      o_win_id = OWT_GNT_NONE;
      if (i_wdg_req) begin
         o_win_id = OWT_GNT_WDG;
      end else if (i_rr == OWT_RR_SPI) begin
         if (i_spi_req) begin
            o_win_id = OWT_GNT_SPI;
         end else if (i_scan_req) begin
            o_win_id = OWT_GNT_SCAN;
         end else begin
            o_win_id = OWT_GNT_NONE;
         end
      end else begin
         if (i_scan_req) begin
            o_win_id = OWT_GNT_SCAN;
         end else if (i_spi_req) begin
            o_win_id = OWT_GNT_SPI;
         end else begin
            o_win_id = OWT_GNT_NONE;
         end
      end
   end

endmodule

// File: rtl/lv_owt_tx_arb.sv
// LV OWT TX arbiter: grants one requester, sends its frame, waits for the HV
// response with timeout/retry, and returns a per-requester ack with error flag.
module lv_owt_tx_arb
   import lv_owt_tx_arb_pkg::*;
#(
   parameter int FRM_W   = 24,
   parameter int TMO_CYC = 255,
   parameter int TMO_W   = 8,
   parameter int RETRY_N = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_owt_com_en,
   input  logic             i_wdg_req,
   input  logic             i_spi_req,
   input  logic             i_scan_req,
   input  logic [FRM_W-1:0] i_wdg_frm,
   input  logic [FRM_W-1:0] i_spi_frm,
   input  logic [FRM_W-1:0] i_scan_frm,
   output logic             o_wdg_ack,
   output logic             o_spi_ack,
   output logic             o_scan_ack,
   output logic             o_ack_err,
   output logic             o_tx_vld,
   output logic [FRM_W-1:0] o_tx_frm,
   input  logic             i_tx_rdy,
   input  logic             i_rx_ack,
   output logic [1:0]       o_gnt_id,
   output logic             o_busy
);

   localparam int RTY_W = (RETRY_N < 1) ? 1 : $clog2(RETRY_N + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(RETRY_N);

   owt_arb_st_e      state_q, state_d;
   logic             rr_q, rr_d;
   logic [RTY_W-1:0] retry_cnt_q, retry_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             err_q, err_d;
   owt_gnt_t         gnt_id_q, gnt_id_d;
   logic [FRM_W-1:0] tx_frm_q, tx_frm_d;
   logic             tx_vld_q, tx_vld_d;
   logic [2:0]       ack_q, ack_d;          // {scan, spi, wdg}
   logic             ack_err_q, ack_err_d;
   logic             busy_q, busy_d;

   owt_gnt_t         pick_id;
   logic [FRM_W-1:0] pick_frm;

   lv_owt_arb_pick u_pick (
      .i_wdg_req  (i_wdg_req),
      .i_spi_req  (i_spi_req),
      .i_scan_req (i_scan_req),
      .i_rr       (rr_q),
      .o_win_id   (pick_id)
   );

   // Frame of the current picker winner, latched on grant
   always_comb begin
      case (pick_id)
         OWT_GNT_WDG:  pick_frm = i_wdg_frm;
         OWT_GNT_SPI:  pick_frm = i_spi_frm;
         OWT_GNT_SCAN: pick_frm = i_scan_frm;
         default:      pick_frm = {FRM_W{1'b0}};
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         rr_q        <= OWT_RR_SPI;
         retry_cnt_q <= {RTY_W{1'b0}};
         tmo_cnt_q   <= {TMO_W{1'b0}};
         err_q       <= 1'b0;
         gnt_id_q    <= OWT_GNT_NONE;
         tx_frm_q    <= {FRM_W{1'b0}};
         tx_vld_q    <= 1'b0;
         ack_q       <= 3'b000;
         ack_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         retry_cnt_q <= retry_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         err_q       <= err_d;
         gnt_id_q    <= gnt_id_d;
         tx_frm_q    <= tx_frm_d;
         tx_vld_q    <= tx_vld_d;
         ack_q       <= ack_d;
         ack_err_q   <= ack_err_d;
         busy_q      <= busy_d;
      end
   end

   // Next state: grant, send, wait with timeout/retry, abort when the channel is disabled
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      retry_cnt_d = retry_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      err_d       = err_q;
      gnt_id_d    = gnt_id_q;
      tx_frm_d    = tx_frm_q;
      case (state_q)
         ST_IDLE: begin
            if (i_owt_com_en && (pick_id != OWT_GNT_NONE)) begin
               state_d     = ST_SEND;
               gnt_id_d    = pick_id;
               tx_frm_d    = pick_frm;
               retry_cnt_d = {RTY_W{1'b0}};
               err_d       = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (!i_owt_com_en) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else if (i_tx_rdy) begin
               state_d   = ST_WAIT_RSP;
               tmo_cnt_d = {TMO_W{1'b0}};
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_WAIT_RSP: begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if (!i_owt_com_en) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else if (i_rx_ack) begin
               // A response arriving on the timeout cycle still counts as success
               state_d = ST_DONE;
               err_d   = 1'b0;
            end else if (tmo_cnt_q == TMO_LAST) begin
               if (retry_cnt_q < RTY_MAX) begin
                  retry_cnt_d = retry_cnt_q + RTY_W'(1);
                  state_d     = ST_SEND;
               end else begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end
            end else begin
               state_d = ST_WAIT_RSP;
            end
         end
         ST_DONE: begin
            state_d  = ST_IDLE;
            rr_d     = owt_rr_next(rr_q, gnt_id_q);
            gnt_id_d = OWT_GNT_NONE;
            err_d    = 1'b0;
         end
         default: begin
            state_d  = ST_IDLE;
            gnt_id_d = OWT_GNT_NONE;
         end
      endcase
   end

   // Registered outputs derived from the upcoming state so they align with it
   always_comb begin
      tx_vld_d  = 1'b0;
      ack_d     = 3'b000;
      ack_err_d = 1'b0;
      busy_d    = (state_d != ST_IDLE);
      if (state_d == ST_SEND) begin
         tx_vld_d = 1'b1;
      end else begin
         tx_vld_d = 1'b0;
      end
      if (state_d == ST_DONE) begin
         ack_err_d = err_d;
         case (gnt_id_d)
            OWT_GNT_WDG:  ack_d = 3'b001;
            OWT_GNT_SPI:  ack_d = 3'b010;
            OWT_GNT_SCAN: ack_d = 3'b100;
            default:      ack_d = 3'b000;
         endcase
      end else begin
         ack_d     = 3'b000;
         ack_err_d = 1'b0;
      end
   end

   assign o_tx_vld   = tx_vld_q;
   assign o_tx_frm   = tx_frm_q;
   assign o_gnt_id   = gnt_id_q;
   assign o_wdg_ack  = ack_q[0];
   assign o_spi_ack  = ack_q[1];
   assign o_scan_ack = ack_q[2];
   assign o_ack_err  = ack_err_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_lv_owt_tx_arb.sv
// Scoreboard bench for lv_owt_tx_arb: the driver predicts each grant and its
// outcome from the arbitration rules and queues it; an independent monitor
// checks grants and acks as the DUT presents them.
module tb_lv_owt_tx_arb;

   localparam int FRM_W   = 24;
   localparam int TMO_CYC = 4;
   localparam int TMO_W   = 4;
   localparam int RETRY_N = 2;
   localparam int NEVER   = 99;

   logic             clk = 1'b0;
   logic             i_rst_n, i_owt_com_en;
   logic             i_wdg_req, i_spi_req, i_scan_req;
   logic [FRM_W-1:0] i_wdg_frm, i_spi_frm, i_scan_frm;
   logic             o_wdg_ack, o_spi_ack, o_scan_ack, o_ack_err;
   logic             o_tx_vld, i_tx_rdy, i_rx_ack, o_busy;
   logic [FRM_W-1:0] o_tx_frm;
   logic [1:0]       o_gnt_id;

   always #5 clk = ~clk;

   lv_owt_tx_arb #(.FRM_W(FRM_W), .TMO_CYC(TMO_CYC), .TMO_W(TMO_W), .RETRY_N(RETRY_N)) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_owt_com_en(i_owt_com_en),
      .i_wdg_req(i_wdg_req), .i_spi_req(i_spi_req), .i_scan_req(i_scan_req),
      .i_wdg_frm(i_wdg_frm), .i_spi_frm(i_spi_frm), .i_scan_frm(i_scan_frm),
      .o_wdg_ack(o_wdg_ack), .o_spi_ack(o_spi_ack), .o_scan_ack(o_scan_ack),
      .o_ack_err(o_ack_err), .o_tx_vld(o_tx_vld), .o_tx_frm(o_tx_frm),
      .i_tx_rdy(i_tx_rdy), .i_rx_ack(i_rx_ack), .o_gnt_id(o_gnt_id), .o_busy(o_busy)
   );

   typedef struct {
      int gnt;
      int frm;
      int err;
      int att;
      int wcyc;
      bit kill;
   } exp_t;

   exp_t exp_q[$];
   int   rd_idx = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   // responder configuration (written by the driver only)
   int cfg_id = 0, cfg_att = 0, cfg_dly = 0, cfg_rdy = 0;

   // reference model: pending requests (index = id-1), their frames, rr holder id (2 spi / 3 scan)
   bit               req_m[3];
   logic [FRM_W-1:0] frm_m[3];
   int               rr_m = 2;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic finish_sim();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   endtask

   function automatic int predict();
      if (req_m[0]) return 1;
      if (req_m[rr_m-1]) return rr_m;
      if (req_m[(5 - rr_m) - 1]) return 5 - rr_m;
      return 0;
   endfunction

   task automatic drive_reqs();
      i_wdg_req  = req_m[0];
      i_spi_req  = req_m[1];
      i_scan_req = req_m[2];
      i_wdg_frm  = frm_m[0];
      i_spi_frm  = frm_m[1];
      i_scan_frm = frm_m[2];
   endtask

   task automatic add_req(input int id, input logic [FRM_W-1:0] f);
      req_m[id-1] = 1'b1;
      frm_m[id-1] = f;
      drive_reqs();
   endtask

   // One arbitrated transaction: predict, queue expectation, wait for ack, release requester.
   // att = attempt index (0-based) that gets a response after dly wait cycles, NEVER = no response.
   task automatic do_txn(input int att, input int dly, input int rdy, input int abort_j,
                         input bit chk_lat, output int w_o);
      exp_t e;
      int   w, n, wc;
      bit   got;
      w = predict();
      w_o = w;
      if (w == 0) begin
         chk("txn_has_req", 0, 1);
         return;
      end
      e.gnt  = w;
      e.frm  = int'(frm_m[w-1]);
      e.kill = 1'b0;
      if (abort_j > 0) begin
         e.att = 1; e.err = 1; e.wcyc = abort_j;
      end else if (att <= RETRY_N) begin
         e.att = att + 1; e.err = 0; e.wcyc = att * TMO_CYC + dly + 1;
      end else begin
         e.att = RETRY_N + 1; e.err = 1; e.wcyc = (RETRY_N + 1) * TMO_CYC;
      end
      exp_q.push_back(e);
      cfg_att = (abort_j > 0) ? NEVER : att;
      cfg_dly = dly;
      cfg_rdy = rdy;
      cfg_id++;
      i_owt_com_en = 1'b1;
      if (chk_lat) begin
         @(negedge clk);
         chk("lat_vld", int'(o_tx_vld), 1);
         chk("lat_gnt", int'(o_gnt_id), w);
         chk("lat_frm", int'(o_tx_frm), e.frm);
      end
      got = 1'b0; wc = 0; n = 0;
      while (!got && n < 300) begin
         @(negedge clk);
         n++;
         if (o_wdg_ack || o_spi_ack || o_scan_ack) begin
            got = 1'b1;
         end else begin
            if (o_busy && !o_tx_vld) wc++;
            if (abort_j > 0 && wc == abort_j) i_owt_com_en = 1'b0;
         end
      end
      if (!got) begin
         chk("ack_timeout", 0, 1);
         finish_sim();
      end
      req_m[w-1] = 1'b0;
      drive_reqs();
      if (w > 1) rr_m = 5 - w;
      i_owt_com_en = 1'b1;
   endtask

   // PHY responder: drives i_tx_rdy and answers the selected attempt with i_rx_ack
   initial begin : responder
      int seen_id, acc_n, cnt;
      bit pend;
      seen_id = 0; acc_n = 0; cnt = 0; pend = 1'b0;
      i_tx_rdy = 1'b0;
      i_rx_ack = 1'b0;
      forever begin
         @(negedge clk);
         i_rx_ack = 1'b0;
         if (cfg_id != seen_id) begin
            seen_id = cfg_id; acc_n = 0; pend = 1'b0;
         end
         if (!i_rst_n) begin
            pend = 1'b0;
         end else if (pend) begin
            if (cnt == 0) begin
               i_rx_ack = 1'b1;
               pend = 1'b0;
            end else begin
               cnt--;
            end
         end
         case (cfg_rdy)
            1:       i_tx_rdy = ($urandom_range(0, 2) != 0);
            2:       i_tx_rdy = 1'b0;
            default: i_tx_rdy = 1'b1;
         endcase
         if (i_rst_n && o_tx_vld && i_tx_rdy && i_owt_com_en) begin
            if (acc_n == cfg_att) begin
               pend = 1'b1;
               cnt  = cfg_dly;
            end
            acc_n++;
         end
      end
   end

   // Monitor: checks each grant and each ack against the queued expectation
   initial begin : monitor
      bit   prev_vld;
      int   att_c, wc_c, got_id;
      bit   any_ack;
      exp_t e;
      prev_vld = 1'b0; att_c = 0; wc_c = 0;
      forever begin
         @(negedge clk);
         if (!i_rst_n) begin
            prev_vld = 1'b0; att_c = 0; wc_c = 0;
         end else begin
            any_ack = o_wdg_ack || o_spi_ack || o_scan_ack;
            if (o_tx_vld && !prev_vld) begin
               att_c++;
               if (att_c == 1) begin
                  if (rd_idx >= exp_q.size()) begin
                     chk("unexpected_grant", int'(o_gnt_id), 0);
                  end else begin
                     e = exp_q[rd_idx];
                     chk("grant_id", int'(o_gnt_id), e.gnt);
                     chk("grant_frm", int'(o_tx_frm), e.frm);
                     if (e.kill) begin
                        rd_idx++;
                        att_c = 0;
                     end
                  end
               end
            end
            if (o_busy && !o_tx_vld && !any_ack) wc_c++;
            if (!any_ack && o_ack_err) chk("stray_ack_err", 1, 0);
            if (any_ack) begin
               got_id = o_wdg_ack ? 1 : (o_spi_ack ? 2 : 3);
               if (rd_idx >= exp_q.size()) begin
                  chk("unexpected_ack", got_id, 0);
               end else begin
                  e = exp_q[rd_idx];
                  rd_idx++;
                  chk("ack_onehot", $countones({o_wdg_ack, o_spi_ack, o_scan_ack}), 1);
                  chk("ack_id", got_id, e.gnt);
                  chk("ack_gnt_id", int'(o_gnt_id), e.gnt);
                  chk("ack_err", int'(o_ack_err), e.err);
                  chk("attempts", att_c, e.att);
                  chk("wait_cycles", wc_c, e.wcyc);
               end
               att_c = 0; wc_c = 0;
            end
            prev_vld = o_tx_vld;
         end
      end
   end

   // Driver: directed scenarios, then randomized rounds
   initial begin : driver
      int   w, n, mode, att, dly, ab;
      exp_t e;
      i_rst_n = 1'b0;
      i_owt_com_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_m[k] = 1'b0;
         frm_m[k] = {FRM_W{1'b0}};
      end
      drive_reqs();
      repeat (3) @(negedge clk);
      chk("rst_outputs", int'({o_tx_vld, o_wdg_ack, o_spi_ack, o_scan_ack, o_ack_err,
                               o_busy, o_gnt_id, o_tx_frm}), 0);
      i_rst_n = 1'b1;

      // all three at once: wdg, then spi, then scan; minimum-latency first transaction
      add_req(1, 24'h111111);
      add_req(2, 24'h222222);
      add_req(3, 24'h333333);
      do_txn(0, 0, 0, 0, 1'b1, w);
      do_txn(0, 1, 0, 0, 1'b0, w);
      do_txn(0, 2, 0, 0, 1'b0, w);
      @(negedge clk);
      chk("idle_busy", int'(o_busy), 0);
      chk("idle_gnt", int'(o_gnt_id), 0);

      // single spi frame, response on the timeout cycle of the first attempt
      add_req(2, 24'hA51234);
      do_txn(0, TMO_CYC - 1, 0, 0, 1'b1, w);
      @(negedge clk);
      chk("idle_after_done", int'(o_busy), 0);

      // spi and scan held continuously, wdg interjects once
      add_req(2, FRM_W'($urandom));
      add_req(3, FRM_W'($urandom));
      for (int i = 0; i < 5; i++) begin
         if (i == 1) add_req(1, FRM_W'($urandom));
         do_txn(0, $urandom_range(0, TMO_CYC - 1), 0, 0, 1'b0, w);
         if (w > 1) add_req(w, FRM_W'($urandom));
      end
      while (req_m[0] || req_m[1] || req_m[2]) do_txn(0, 0, 0, 0, 1'b0, w);

      // no response at all: all retries exhausted
      add_req(3, FRM_W'($urandom));
      do_txn(NEVER, 0, 0, 0, 1'b0, w);
      // success on a retry, random tx ready
      add_req(2, FRM_W'($urandom));
      do_txn(1, 2, 1, 0, 1'b0, w);
      // response on the timeout cycle of the last attempt
      add_req(1, FRM_W'($urandom));
      do_txn(RETRY_N, TMO_CYC - 1, 0, 0, 1'b0, w);
      // abort during WAIT_RSP
      add_req(2, FRM_W'($urandom));
      do_txn(NEVER, 0, 0, 2, 1'b0, w);

      // channel disabled in IDLE: no grant
      i_owt_com_en = 1'b0;
      add_req(3, FRM_W'($urandom));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("dis_no_grant", int'({o_busy, o_tx_vld, o_gnt_id}), 0);
      end
      do_txn(0, 1, 0, 0, 1'b1, w);

      // reset while stuck in SEND: outputs clear, no ack
      add_req(2, FRM_W'($urandom));
      e.gnt = predict(); e.frm = int'(frm_m[e.gnt-1]); e.err = 0; e.att = 1; e.wcyc = 0; e.kill = 1'b1;
      exp_q.push_back(e);
      cfg_rdy = 2; cfg_att = NEVER; cfg_id++;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!o_tx_vld && n < 20);
      chk("send_reached", int'(o_tx_vld), 1);
      repeat (2) @(negedge clk);
      i_rst_n = 1'b0;
      for (int k = 0; k < 3; k++) req_m[k] = 1'b0;
      drive_reqs();
      rr_m = 2;
      @(negedge clk);
      chk("rst_in_send", int'({o_tx_vld, o_wdg_ack, o_spi_ack, o_scan_ack, o_ack_err,
                               o_busy, o_gnt_id, o_tx_frm}), 0);
      i_rst_n = 1'b1;
      cfg_rdy = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_ack_after_rst", int'({o_wdg_ack, o_spi_ack, o_scan_ack, o_busy}), 0);
      end

      // randomized rounds
      for (int r = 0; r < 40; r++) begin
         for (int k = 1; k <= 3; k++)
            if (!req_m[k-1] && ($urandom_range(0, 1) == 1)) add_req(k, FRM_W'($urandom));
         if (!(req_m[0] || req_m[1] || req_m[2])) add_req($urandom_range(1, 3), FRM_W'($urandom));
         mode = $urandom_range(0, 5);
         att  = (mode == 0) ? NEVER : $urandom_range(0, RETRY_N);
         dly  = $urandom_range(0, TMO_CYC - 1);
         ab   = (mode == 5) ? $urandom_range(1, TMO_CYC - 1) : 0;
         do_txn(att, dly, $urandom_range(0, 1), ab, 1'b0, w);
      end
      while (req_m[0] || req_m[1] || req_m[2]) do_txn(0, 0, 0, 0, 1'b0, w);
      repeat (4) @(negedge clk);
      chk("all_expect_consumed", rd_idx, exp_q.size());
      finish_sim();
   end

endmodule
